// File: rtl/mem_pkt_rx_queue_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkt_rx_queue_pkg
// Shared definitions for the LSU-side memPkt receive queue:
//   - memPkt       : packet issued by AGEN. Its valid bit doubles as the
//                    enqueue request on input and head-valid on output.
//   - MEM_RX_DEPTH : default queue depth. This is also the number of credits
//                    the AGEN sender holds after reset or flush.
//   - ptr_w()      : read/write pointer width for a given depth.
// -----------------------------------------------------------------------------
package mem_pkt_rx_queue_pkg;

  localparam int MEM_RX_DEPTH = 4;

  typedef enum logic [1:0] {
    MEM_OP_LOAD  = 2'd0,
    MEM_OP_STORE = 2'd1,
    MEM_OP_AMO   = 2'd2,
    MEM_OP_FENCE = 2'd3
  } mem_op_e;

  typedef struct packed {
    logic        valid;
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } memPkt;

  // Pointer width for a power-of-two depth. The pointers wrap naturally
  // at DEPTH, so no explicit modulo logic is needed.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_pkt_fifo.sv
// -----------------------------------------------------------------------------
// mem_pkt_fifo
// Generic synchronous FIFO: a storage array, read/write pointers that wrap,
// and an occupancy count. It has no overflow or underflow protection; the
// instantiating block must only push when there is room (or when a pop
// happens in the same cycle) and only pop when the FIFO is not empty.
//
// Parameters : T (payload type), DEPTH (power of 2, >= 2)
// Ports      : clk, reset_n (synchronous, active-low)
//              i_clear    - empties the queue; takes priority over push/pop
//              i_push     - write i_wr_data at the tail
//              i_pop      - advance the head
//              o_rd_data  - current head entry (meaningful only when o_count != 0)
//              o_count    - number of entries held, range 0..DEPTH
// -----------------------------------------------------------------------------
module mem_pkt_fifo
  import mem_pkt_rx_queue_pkg::*;
#(
  parameter type T          = logic,
  parameter int  DEPTH      = 4,
  localparam int PTR_W      = ptr_w(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_clear,
  input  logic           i_push,
  input  logic           i_pop,
  input  T               i_wr_data,
  output T               o_rd_data,
  output logic [PTR_W:0] o_count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  T                 r_mem [DEPTH];

  // NOTE: sequential state uses non-blocking (<=) assignments only. All
  // flops then sample the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset. Only entries
  // between rd_ptr and wr_ptr are ever observed, and leaving it unreset lets
  // it map onto plain registers or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/mem_pkt_rx_queue.sv
// -----------------------------------------------------------------------------
// mem_pkt_rx_queue
// LSU-side receiver for memPkt traffic from the AGEN stage. Packets are
// buffered in a DEPTH-entry FIFO and presented to the LSU using valid/ready.
// Each packet the LSU consumes returns one credit to AGEN as a registered pulse.
// AGEN holds DEPTH credits after reset or flush, so in normal operation the
// queue is never full when a packet arrives. If a packet does arrive while the
// queue is full, it is dropped and the sticky overflow_o is set.
//
// Optional feature (macro MEM_PKT_RX_BYPASS_EN):
//   When the queue is empty, an incoming valid packet drives memPacket_o
//   combinationally in the same cycle. If lsuReady_i is also high, the packet
//   is consumed without ever being written into the queue. When the macro is
//   undefined, there is no combinational path from input to output.
//
// Ports:
//   clk, reset_n    core clock; synchronous active-low reset
//   flush_i         pipeline flush: empties the queue; overflow_o is held
//   memPacket_i     packet from AGEN (valid = enqueue request)
//   lsuReady_i      LSU accepts the head packet this cycle
//   memPacket_o     head packet (valid = head valid); zero when not valid
//   creditReturn_o  one-cycle pulse, one cycle after each consumed packet
//   occupancy_o     number of entries currently held
//   overflow_o      sticky: a packet arrived with no free entry
// -----------------------------------------------------------------------------
module mem_pkt_rx_queue
  import mem_pkt_rx_queue_pkg::*;
#(
  parameter int  DEPTH = MEM_RX_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush_i,
  input  memPkt          memPacket_i,
  input  logic           lsuReady_i,
  output memPkt          memPacket_o,
  output logic           creditReturn_o,
  output logic [PTR_W:0] occupancy_o,
  output logic           overflow_o
);

  localparam int CNT_W = PTR_W + 1;

  memPkt            w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_fifo_pop;
  logic             w_fifo_push;
  logic             w_bypass_take;
  logic             w_drop;
  logic             w_consume;

  logic             r_credit;
  logic             r_overflow;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults or full assignment first), so no latches are inferred.
  always_comb begin
    w_empty    = (w_count == '0);
    w_full     = (w_count == CNT_W'(DEPTH));
    w_fifo_pop = !w_empty && lsuReady_i;
`ifdef MEM_PKT_RX_BYPASS_EN
    // The packet passes straight through to the LSU. It never occupies a slot.
    w_bypass_take = w_empty && memPacket_i.valid && lsuReady_i;
`else
    w_bypass_take = 1'b0;
`endif
    // A full queue still accepts a packet when the head leaves in the same
    // cycle, because the new packet reuses the freed slot.
    w_fifo_push = memPacket_i.valid && (!w_full || w_fifo_pop) && !w_bypass_take;
    w_drop      = memPacket_i.valid && w_full && !w_fifo_pop;
    w_consume   = w_fifo_pop || w_bypass_take;
  end

  // Flush is passed in as the FIFO clear. Push and pop are masked as well,
  // so no storage write or credit can come from a cycle that is being flushed.
  mem_pkt_fifo #(
    .T     (memPkt),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (flush_i),
    .i_push    (w_fifo_push && !flush_i),
    .i_pop     (w_fifo_pop && !flush_i),
    .i_wr_data (memPacket_i),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  always_comb begin
    memPacket_o = '0;
    if (!w_empty) begin
      memPacket_o       = w_head;
      memPacket_o.valid = 1'b1;
    end
`ifdef MEM_PKT_RX_BYPASS_EN
    else if (memPacket_i.valid) begin
      memPacket_o = memPacket_i;
    end
`endif
  end

  // reset_n has priority over flush_i, so a flush in a reset cycle behaves as
  // a reset and also clears overflow. A flush alone never touches overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_credit   <= 1'b0;
    end else begin
      r_credit <= w_consume;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign creditReturn_o = r_credit;
  assign occupancy_o    = w_count;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_mem_pkt_rx_queue.sv
// -----------------------------------------------------------------------------
// tb_mem_pkt_rx_queue
// Self-checking bench for mem_pkt_rx_queue. A behavioural model (a queue of
// packets plus expected credit and overflow flags) is stepped once per clock.
// Outputs are compared with the model at every falling edge. Directed
// scenarios come first, followed by a randomized run.
// Build with MEM_PKT_RX_BYPASS_EN defined to model the bypass configuration.
// -----------------------------------------------------------------------------
module tb_mem_pkt_rx_queue;
  import mem_pkt_rx_queue_pkg::*;

  localparam int DEPTH = MEM_RX_DEPTH;
  localparam int PTR_W = ptr_w(DEPTH);
`ifdef MEM_PKT_RX_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  logic           flush_i;
  memPkt          memPacket_i;
  logic           lsuReady_i;
  memPkt          memPacket_o;
  logic           creditReturn_o;
  logic [PTR_W:0] occupancy_o;
  logic           overflow_o;

  always #5 clk = ~clk;

  mem_pkt_rx_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_i        (flush_i),
    .memPacket_i    (memPacket_i),
    .lsuReady_i     (lsuReady_i),
    .memPacket_o    (memPacket_o),
    .creditReturn_o (creditReturn_o),
    .occupancy_o    (occupancy_o),
    .overflow_o     (overflow_o)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: packets held, in arrival order.
  memPkt m_q[$];
  bit    m_credit;
  bit    m_ovf;

  // Snapshot of the outputs taken at the falling edge of the latest step.
  memPkt          s_pkt;
  logic [PTR_W:0] s_occ;
  logic           s_credit;
  logic           s_ovf;

  memPkt idle_pkt = '0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic memPkt mk(input logic [31:0] addr);
    memPkt p;
    p.valid = 1'b1;
    p.op    = mem_op_e'($urandom_range(0, 3));
    p.addr  = addr;
    p.data  = $urandom;
    p.be    = 4'($urandom);
    return p;
  endfunction

  // Compare the current outputs with what the model predicts for this cycle.
  task automatic sample_and_check();
    memPkt exp_pkt;
    bit    exp_v;
    s_pkt    = memPacket_o;
    s_occ    = occupancy_o;
    s_credit = creditReturn_o;
    s_ovf    = overflow_o;
    exp_pkt  = '0;
    exp_v    = 1'b0;
    if (m_q.size() > 0) begin
      exp_pkt = m_q[0];
      exp_v   = 1'b1;
    end else if (BYPASS && memPacket_i.valid) begin
      exp_pkt = memPacket_i;
      exp_v   = 1'b1;
    end
    chk("valid", 96'(s_pkt.valid), 96'(exp_v));
    if (exp_v) chk("head_pkt", 96'(s_pkt), 96'(exp_pkt));
    chk("occupancy", 96'(s_occ), 96'(m_q.size()));
    chk("credit", 96'(s_credit), 96'(m_credit));
    chk("overflow", 96'(s_ovf), 96'(m_ovf));
  endtask

  // Apply one clock edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    int  size;
    bit  deq;
    bit  take;
    bit  room;
    if (!reset_n) begin
      m_q.delete();
      m_credit = 1'b0;
      m_ovf    = 1'b0;
    end else if (flush_i) begin
      m_q.delete();
      m_credit = 1'b0;
    end else begin
      size = m_q.size();
      deq  = (size > 0) && lsuReady_i;
      take = BYPASS && (size == 0) && memPacket_i.valid && lsuReady_i;
      room = (size < DEPTH) || deq;
      if (deq) void'(m_q.pop_front());
      if (memPacket_i.valid && !take) begin
        if (room) m_q.push_back(memPacket_i);
        else      m_ovf = 1'b1;
      end
      m_credit = deq || take;
    end
  endtask

  task automatic step(input memPkt p, input logic rdy, input logic fl,
                      input logic rn, input bit do_chk);
    memPacket_i = p;
    lsuReady_i  = rdy;
    flush_i     = fl;
    reset_n     = rn;
    @(negedge clk);
    if (do_chk) sample_and_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int credits;
    memPkt p;
    reset_n     = 1'b0;
    flush_i     = 1'b0;
    lsuReady_i  = 1'b0;
    memPacket_i = '0;
    m_credit    = 1'b0;
    m_ovf       = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset held for two cycles, then released.
    step(idle_pkt, 1'b0, 1'b0, 1'b0, 1'b0);
    step(idle_pkt, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_pkt_zero", 96'(s_pkt), 96'(0));
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reset_release_occ", 96'(s_occ), 96'(0));

    // 2: fill with 0x10..0x40; a 5th packet is dropped.
    for (int i = 0; i < 4; i++) step(mk(32'h10 * (i + 1)), 1'b0, 1'b0, 1'b1, 1'b1);
    step(mk(32'h99), 1'b0, 1'b0, 1'b1, 1'b1);
    chk("fill_occ", 96'(s_occ), 96'(4));
    chk("fill_head", 96'(s_pkt.addr), 96'(32'h10));
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("overflow_set", 96'(s_ovf), 96'(1));
    chk("overflow_occ", 96'(s_occ), 96'(4));

    // 3: drain in order; one credit per dequeue; ready on empty gives no credit.
    credits = 0;
    for (int i = 0; i < 4; i++) begin
      step(idle_pkt, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("drain_order", 96'(s_pkt.addr), 96'(32'h10 * (i + 1)));
      credits += int'(s_credit);
    end
    step(idle_pkt, 1'b1, 1'b0, 1'b1, 1'b1);
    credits += int'(s_credit);
    chk("drain_credit_count", 96'(credits), 96'(4));
    chk("drain_occ", 96'(s_occ), 96'(0));
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("empty_ready_no_credit", 96'(s_credit), 96'(0));

    // 4: full queue with simultaneous enqueue and dequeue, then pointer wrap.
    step(idle_pkt, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(mk(32'h10 * (i + 1)), 1'b0, 1'b0, 1'b1, 1'b1);
    step(mk(32'h50), 1'b1, 1'b0, 1'b1, 1'b1);
    chk("full_simul_head", 96'(s_pkt.addr), 96'(32'h10));
    for (int i = 0; i < 10; i++) begin
      step(mk(32'h60 + 32'h10 * i), 1'b1, 1'b0, 1'b1, 1'b1);
      chk("wrap_order", 96'(s_pkt.addr), 96'(32'h20 + 32'h10 * i));
      chk("wrap_occ", 96'(s_occ), 96'(4));
    end
    chk("full_simul_no_overflow", 96'(s_ovf), 96'(0));

    // 5: overflow, drop to 3 entries, then flush with same-cycle enq+deq.
    step(mk(32'hAA), 1'b0, 1'b0, 1'b1, 1'b1);
    step(idle_pkt, 1'b1, 1'b0, 1'b1, 1'b1);
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_flush_occ", 96'(s_occ), 96'(3));
    step(mk(32'hBB), 1'b1, 1'b1, 1'b1, 1'b1);
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_occ", 96'(s_occ), 96'(0));
    chk("flush_valid", 96'(s_pkt.valid), 96'(0));
    chk("flush_no_credit", 96'(s_credit), 96'(0));
    chk("flush_keeps_overflow", 96'(s_ovf), 96'(1));
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_no_credit_next", 96'(s_credit), 96'(0));

    // 6: packet 0x60 arrives at an empty queue with ready high.
    step(mk(32'h60), 1'b1, 1'b0, 1'b1, 1'b1);
    chk("bypass_same_cycle", 96'(s_pkt.valid ? s_pkt.addr : 32'h0),
        96'(BYPASS ? 32'h60 : 32'h0));
    step(idle_pkt, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bypass_next_addr", 96'(s_pkt.valid ? s_pkt.addr : 32'h0),
        96'(BYPASS ? 32'h0 : 32'h60));
    chk("bypass_next_occ", 96'(s_occ), 96'(BYPASS ? 0 : 1));
    chk("bypass_next_credit", 96'(s_credit), 96'(BYPASS ? 1 : 0));
    step(idle_pkt, 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      p       = mk($urandom);
      p.valid = ($urandom_range(0, 9) < 6);
      step(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) != 0), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
